// File: rtl/sha256_pkg.sv
// Shared definitions for the SHA-256 message padding controller: FSM states,
// block geometry constants and the message-length helper.
package sha256_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ABSORB,
        PAD_ONE,
        PAD_ZERO,
        LEN_HI,
        LEN_LO,
        WAIT_CORE,
        DONE
    } pad_state_e;

    localparam int         WORDS_PER_BLOCK = 16;
    localparam logic [7:0] PAD_BYTE        = 8'h80;
    localparam logic [3:0] LEN_WORD_HI     = 4'd14;
    localparam logic [3:0] LEN_WORD_LO     = 4'd15;
    localparam logic [3:0] LAST_WORD       = 4'(WORDS_PER_BLOCK - 1);

    // Message length in bits as carried in the final two words of the last block.
    function automatic logic [63:0] bits_of_bytes(input logic [63:0] n_bytes);
        return n_bytes << 3;
    endfunction

endpackage

// File: rtl/sha256_word_packer.sv
// Big-endian byte-to-word packer with an optional 0x80 pad view that places the
// pad byte at the next free byte lane of the partial word.
module sha256_word_packer
    import sha256_pkg::*;
#(
    parameter int WORD_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    input  logic              pad_insert,
    input  logic              clear,
    output logic [WORD_W-1:0] word_data,
    output logic              word_full
);

    logic [WORD_W-1:0] word_q;
    logic [1:0]        byte_pos;
    logic [4:0]        shift;

    // Lane 0 sits at the top of the word, so the shift is (3 - pos) * 8.
    assign shift = {~byte_pos, 3'b000};

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            word_q    <= '0;
            byte_pos  <= 2'd0;
            word_full <= 1'b0;
        end else if (clear) begin
            word_q    <= '0;
            byte_pos  <= 2'd0;
            word_full <= 1'b0;
        end else if (byte_valid && !word_full) begin
            word_q   <= word_q | (WORD_W'(byte_data) << shift);
            byte_pos <= byte_pos + 2'd1;
            if (byte_pos == 2'd3) begin
                word_full <= 1'b1;
            end
        end
    end

    // Unwritten lanes are always zero, so OR-ing in the pad byte yields 80 00.. tail.
    assign word_data = pad_insert ? (word_q | (WORD_W'(PAD_BYTE) << shift)) : word_q;

endmodule

// File: rtl/sha256_pad_ctrl.sv
// SHA-256 message padding controller: absorbs message bytes, packs them into
// 32-bit words and appends the 0x80 pad, zero fill and 64-bit bit length.
module sha256_pad_ctrl
    import sha256_pkg::*;
#(
    parameter int MAX_LEN_BITS = 32,
    parameter int WORD_W       = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    input  logic              msg_end,
    output logic              word_valid,
    output logic [WORD_W-1:0] word_data,
    input  logic              word_ready,
    output logic [3:0]        word_index,
    output logic              first_block,
    output logic              final_block,
    input  logic              core_done,
    output logic              msg_done,
    output logic              busy
);

    pad_state_e              state, state_n;
    logic [3:0]              word_idx, word_idx_n;
    logic [MAX_LEN_BITS-1:0] byte_count;
    logic                    end_seen, end_seen_n;
    logic                    pad_done, pad_done_n;
    logic                    first_blk, first_blk_n;
    logic                    final_blk, final_blk_n;

    logic                    byte_acc;
    logic                    pk_pad;
    logic                    pk_clear;
    logic                    pk_full;
    logic [WORD_W-1:0]       pk_word;
    logic [63:0]             bit_len;

    assign byte_acc = in_valid && in_ready;
    assign bit_len  = bits_of_bytes(64'(byte_count));

    sha256_word_packer #(
        .WORD_W (WORD_W)
    ) u_packer (
        .clock      (clock),
        .reset      (reset),
        .byte_valid (byte_acc),
        .byte_data  (in_data),
        .pad_insert (pk_pad),
        .clear      (pk_clear),
        .word_data  (pk_word),
        .word_full  (pk_full)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            word_idx  <= 4'd0;
            end_seen  <= 1'b0;
            pad_done  <= 1'b0;
            first_blk <= 1'b0;
            final_blk <= 1'b0;
        end else begin
            state     <= state_n;
            word_idx  <= word_idx_n;
            end_seen  <= end_seen_n;
            pad_done  <= pad_done_n;
            first_blk <= first_blk_n;
            final_blk <= final_blk_n;
        end
    end

    // A new message restarts the count; it wraps silently at 2^MAX_LEN_BITS.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            byte_count <= '0;
        end else if (state == IDLE) begin
            byte_count <= byte_acc ? MAX_LEN_BITS'(1) : '0;
        end else if (byte_acc) begin
            byte_count <= byte_count + MAX_LEN_BITS'(1);
        end
    end

    always_comb begin
        state_n     = state;
        word_idx_n  = word_idx;
        end_seen_n  = end_seen;
        pad_done_n  = pad_done;
        first_blk_n = first_blk;
        final_blk_n = final_blk;
        in_ready    = 1'b0;
        word_valid  = 1'b0;
        word_data   = '0;
        pk_pad      = 1'b0;
        pk_clear    = 1'b0;
        msg_done    = 1'b0;

        case (state)
            IDLE: begin
                // Held low while reset is asserted so every output reads zero.
                in_ready = reset;
                if (in_valid) begin
                    state_n     = ABSORB;
                    first_blk_n = 1'b1;
                    end_seen_n  = msg_end;
                    word_idx_n  = 4'd0;
                end else if (msg_end) begin
                    state_n     = PAD_ONE;
                    first_blk_n = 1'b1;
                    final_blk_n = 1'b1;
                    end_seen_n  = 1'b1;
                    word_idx_n  = 4'd0;
                end
            end

            ABSORB: begin
                in_ready   = !pk_full && !end_seen;
                word_valid = pk_full;
                word_data  = pk_word;
                if (msg_end) begin
                    end_seen_n = 1'b1;
                end
                if (pk_full && word_ready) begin
                    pk_clear   = 1'b1;
                    word_idx_n = word_idx + 4'd1;
                    if (word_idx == LAST_WORD) begin
                        state_n = WAIT_CORE;
                    end
                end else if (!pk_full && end_seen) begin
                    // The pad lands in the word now being filled; the length fits
                    // in this block only if that word is ahead of the length words.
                    state_n     = PAD_ONE;
                    final_blk_n = (word_idx < LEN_WORD_HI);
                end
            end

            PAD_ONE: begin
                word_valid = 1'b1;
                pk_pad     = 1'b1;
                word_data  = pk_word;
                if (word_ready) begin
                    pk_clear   = 1'b1;
                    pad_done_n = 1'b1;
                    word_idx_n = word_idx + 4'd1;
                    if (word_idx == LAST_WORD) begin
                        state_n = WAIT_CORE;
                    end else if (final_blk && (word_idx == LEN_WORD_HI - 4'd1)) begin
                        state_n = LEN_HI;
                    end else begin
                        state_n = PAD_ZERO;
                    end
                end
            end

            PAD_ZERO: begin
                word_valid = 1'b1;
                if (word_ready) begin
                    word_idx_n = word_idx + 4'd1;
                    if (word_idx == LAST_WORD) begin
                        state_n = WAIT_CORE;
                    end else if (final_blk && (word_idx == LEN_WORD_HI - 4'd1)) begin
                        state_n = LEN_HI;
                    end
                end
            end

            LEN_HI: begin
                word_valid = 1'b1;
                word_data  = WORD_W'(bit_len >> 32);
                if (word_ready) begin
                    word_idx_n = LEN_WORD_LO;
                    state_n    = LEN_LO;
                end
            end

            LEN_LO: begin
                word_valid = 1'b1;
                word_data  = WORD_W'(bit_len);
                if (word_ready) begin
                    word_idx_n = 4'd0;
                    state_n    = WAIT_CORE;
                end
            end

            WAIT_CORE: begin
                if (core_done) begin
                    first_blk_n = 1'b0;
                    if (final_blk) begin
                        state_n = DONE;
                    end else if (pad_done) begin
                        state_n     = PAD_ZERO;
                        final_blk_n = 1'b1;
                    end else if (end_seen) begin
                        state_n     = PAD_ONE;
                        final_blk_n = 1'b1;
                    end else begin
                        state_n = ABSORB;
                    end
                end
            end

            DONE: begin
                msg_done    = 1'b1;
                state_n     = IDLE;
                word_idx_n  = 4'd0;
                end_seen_n  = 1'b0;
                pad_done_n  = 1'b0;
                first_blk_n = 1'b0;
                final_blk_n = 1'b0;
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign word_index  = word_idx;
    assign first_block = first_blk;
    assign final_block = final_blk;
    assign busy        = (state != IDLE) && (state != DONE);

endmodule

// File: tb/tb_sha256_pad_ctrl.sv
// Scoreboard bench for sha256_pad_ctrl: directed messages push hand-computed
// words; a monitor pops and compares every word transfer and plays the core.
module tb_sha256_pad_ctrl;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready;
    logic        msg_end = 1'b0;
    logic        word_valid;
    logic [31:0] word_data;
    logic        word_ready = 1'b1;
    logic [3:0]  word_index;
    logic        first_block;
    logic        final_block;
    logic        core_done = 1'b0;
    logic        msg_done;
    logic        busy;

    always #5 clock = ~clock;

    sha256_pad_ctrl #(
        .MAX_LEN_BITS (32),
        .WORD_W       (32)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .msg_end     (msg_end),
        .word_valid  (word_valid),
        .word_data   (word_data),
        .word_ready  (word_ready),
        .word_index  (word_index),
        .first_block (first_block),
        .final_block (final_block),
        .core_done   (core_done),
        .msg_done    (msg_done),
        .busy        (busy)
    );

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  idx;
        logic        first;
        logic        fin;
    } exp_t;

    exp_t        exp_q[$];
    int          total = 0;
    int          bad = 0;
    int          done_cnt = 0;
    int          core_wait = 0;
    int          stall_left = 0;
    bit          stall_en = 1'b0;
    bit          stall_done = 1'b0;
    logic [31:0] held = 32'h0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s actual=timeout required=event", name);
    endtask

    task automatic push_w(input logic [31:0] d, input int idx, input bit first, input bit fin);
        exp_t e;
        e.data  = d;
        e.idx   = 4'(idx);
        e.first = first;
        e.fin   = fin;
        exp_q.push_back(e);
    endtask

    task automatic push_zeros(input int from, input int to, input bit first, input bit fin);
        for (int k = from; k <= to; k++) push_w(32'h0, k, first, fin);
    endtask

    // Message byte i has value i, so word k reads {4k, 4k+1, 4k+2, 4k+3}.
    task automatic push_seq(input int n_words, input bit first);
        for (int k = 0; k < n_words; k++)
            push_w({8'(4*k), 8'(4*k+1), 8'(4*k+2), 8'(4*k+3)}, k, first, 1'b0);
    endtask

    task automatic push_abc();
        push_w(32'h61626380, 0, 1'b1, 1'b1);
        push_zeros(1, 14, 1'b1, 1'b1);
        push_w(32'h00000018, 15, 1'b1, 1'b1);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit with_end);
        int n;
        in_valid = 1'b1;
        in_data  = b;
        msg_end  = with_end;
        n = 0;
        while (!in_ready && n < 200) begin
            @(negedge clock);
            n++;
        end
        if (n >= 200) fail_now("byte_accept");
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        msg_end  = 1'b0;
    endtask

    task automatic send_seq(input int n, input bit end_last);
        for (int i = 0; i < n; i++) send_byte(8'(i), end_last && (i == n - 1));
    endtask

    task automatic send_end();
        msg_end = 1'b1;
        @(posedge clock);
        #1;
        msg_end = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int prev;
        int n;
        prev = done_cnt;
        n = 0;
        while (done_cnt == prev && n < 3000) begin
            @(negedge clock);
            n++;
        end
        chk({name, "_msg_done"}, 64'(done_cnt), 64'(prev + 1));
        chk({name, "_words_left"}, 64'(exp_q.size()), 64'd0);
        @(negedge clock);
        chk({name, "_done_pulse_end"}, {62'd0, msg_done, in_ready}, 64'd1);
    endtask

    // Monitor: ready/stall control, core model and word scoreboard in one process.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (core_done) core_done = 1'b0;
            if (core_wait > 0) begin
                core_wait--;
                if (core_wait == 0) core_done = 1'b1;
            end
            if (stall_left > 0) begin
                chk("stall_word_data", word_data, held);
                chk("stall_word_index", word_index, 4'd5);
                chk("stall_in_ready", in_ready, 1'b0);
                stall_left--;
                if (stall_left == 0) word_ready = 1'b1;
            end else if (stall_en && !stall_done && word_valid && word_index == 4'd5) begin
                word_ready = 1'b0;
                held       = word_data;
                stall_left = 3;
                stall_done = 1'b1;
            end
            if (word_valid && word_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_word actual=%0h idx=%0d required=none", word_data, word_index);
                end else begin
                    e = exp_q.pop_front();
                    chk("word_data", word_data, e.data);
                    chk("word_index", word_index, e.idx);
                    chk("first_block", first_block, e.first);
                    if (e.idx >= 4'd14) chk("final_block", final_block, e.fin);
                    if (e.idx == 4'd15) core_wait = 3;
                end
            end
            if (msg_done) begin
                done_cnt++;
                chk("busy_at_done", busy, 1'b0);
            end
        end
    end

    initial begin
        int prev;
        reset = 1'b0;
        repeat (2) @(negedge clock);
        chk("reset_in_ready", in_ready, 1'b0);
        chk("reset_flags", {word_valid, busy, msg_done, first_block, final_block}, 5'b0);
        chk("reset_word", {word_data, word_index}, 36'h0);
        @(negedge clock);
        reset = 1'b1;
        #1;
        chk("release_in_ready", in_ready, 1'b1);
        @(posedge clock);
        #1;

        // "abc" followed by a separate msg_end pulse
        push_abc();
        send_byte(8'h61, 1'b0);
        send_byte(8'h62, 1'b0);
        send_byte(8'h63, 1'b0);
        chk("abc_busy", busy, 1'b1);
        send_end();
        wait_done("abc");

        // empty message
        push_w(32'h80000000, 0, 1'b1, 1'b1);
        push_zeros(1, 15, 1'b1, 1'b1);
        send_end();
        wait_done("empty");

        // 55 bytes: pad closes word 13, length 0x1B8 fits in the same block
        push_seq(13, 1'b1);
        push_w(32'h34353680, 13, 1'b1, 1'b1);
        push_w(32'h00000000, 14, 1'b1, 1'b1);
        push_w(32'h000001B8, 15, 1'b1, 1'b1);
        send_seq(55, 1'b0);
        send_end();
        wait_done("len55");

        // 56 bytes: pad spills into word 14, length needs a second block
        push_seq(14, 1'b1);
        push_w(32'h80000000, 14, 1'b1, 1'b0);
        push_w(32'h00000000, 15, 1'b1, 1'b0);
        push_zeros(0, 14, 1'b0, 1'b1);
        push_w(32'h000001C0, 15, 1'b0, 1'b1);
        send_seq(56, 1'b0);
        send_end();
        wait_done("len56");

        // 64 bytes, msg_end with the last byte, word 5 stalled for 3 cycles
        stall_en = 1'b1;
        push_seq(16, 1'b1);
        push_w(32'h80000000, 0, 1'b0, 1'b1);
        push_zeros(1, 14, 1'b0, 1'b1);
        push_w(32'h00000200, 15, 1'b0, 1'b1);
        send_seq(64, 1'b1);
        wait_done("len64");
        chk("stall_seen", stall_done, 1'b1);
        stall_en = 1'b0;

        // reset in the middle of a 20-byte message
        prev = done_cnt;
        push_seq(2, 1'b1);
        send_seq(10, 1'b0);
        @(negedge clock);
        chk("pre_reset_busy", busy, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        chk("midreset_flags", {in_ready, word_valid, busy, msg_done, first_block, final_block}, 6'b0);
        chk("midreset_word", {word_data, word_index}, 36'h0);
        repeat (3) @(negedge clock);
        reset = 1'b1;
        #1;
        chk("midreset_release_ready", in_ready, 1'b1);
        repeat (20) @(negedge clock);
        chk("midreset_no_msg_done", 64'(done_cnt), 64'(prev));
        chk("midreset_words_left", 64'(exp_q.size()), 64'd0);
        @(posedge clock);
        #1;
        push_abc();
        send_byte(8'h61, 1'b0);
        send_byte(8'h62, 1'b0);
        send_byte(8'h63, 1'b0);
        send_end();
        wait_done("abc_after_reset");

        // "abc" with msg_end on the same cycle as the third byte
        push_abc();
        send_byte(8'h61, 1'b0);
        send_byte(8'h62, 1'b0);
        send_byte(8'h63, 1'b1);
        wait_done("abc_same_cycle");

        repeat (5) @(negedge clock);
        chk("final_idle", {busy, word_valid}, 2'b00);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
